// File: rtl/mul_unit.sv
// Multiply sequencer: extends RV32M/RV64M operands for the shared signed multiplier core,
// sequences one core run per miss and keeps a one-entry product cache for MULH->MUL reuse.
module mul_unit #(
  parameter int unsigned XLEN  = 32,
  parameter bit          REUSE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [XLEN-1:0]   req_a,
  input  logic [XLEN-1:0]   req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic [XLEN:0]     mul_a,
  output logic [XLEN:0]     mul_b,
  output logic              mul_stb,
  input  logic [2*XLEN+1:0] mul_o,
  input  logic              mul_ack
);

  localparam logic [1:0] OpMul   = 2'b00;
  localparam logic [1:0] OpMulhu = 2'b11;

  typedef enum logic [2:0] {StIdle, StStart, StWait, StResp, StDrain} state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [XLEN:0]       a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]     rsp_data_q, rsp_data_d;
  logic                cache_valid_q, cache_valid_d;
  logic [XLEN:0]       cache_a_q, cache_b_q;
  logic [2*XLEN-1:0]   cache_p_q;
  logic                cache_we;

  logic [XLEN:0]       ext_a, ext_b;
  logic                hit;
  logic [1:0]          unused_mul_hi;

  // Product bits above 2*XLEN-1 only carry the extension sign and are never selected.
  assign unused_mul_hi = mul_o[2*XLEN+1:2*XLEN];

  function automatic logic [XLEN-1:0] sel_half(input logic [1:0] op,
                                                input logic [2*XLEN-1:0] p);
    return (op == OpMul) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  // a is signed except for MULHU; b is signed only for MUL/MULH.
  assign ext_a = {(req_op != OpMulhu) & req_a[XLEN-1], req_a};
  assign ext_b = {~req_op[1] & req_b[XLEN-1], req_b};

  // The low product half does not depend on operand signedness, so MUL can reuse any entry
  // whose low operand bits match.
  assign hit = REUSE && cache_valid_q &&
               ((ext_a == cache_a_q && ext_b == cache_b_q) ||
                (req_op == OpMul && req_a == cache_a_q[XLEN-1:0] &&
                 req_b == cache_b_q[XLEN-1:0]));

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    rsp_data_d    = rsp_data_q;
    cache_we      = 1'b0;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    mul_stb       = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = ~flush & ~rst;
        if (req_valid && req_ready) begin
          op_d = req_op;
          a_d  = ext_a;
          b_d  = ext_b;
          if (hit) begin
            rsp_data_d = sel_half(req_op, cache_p_q);
            state_d    = StResp;
          end else begin
            state_d = StStart;
          end
        end
      end
      StStart: begin
        // The core cannot abort, so the start pulse goes out even when flushed.
        mul_stb = ~rst;
        state_d = flush ? StDrain : StWait;
      end
      StWait: begin
        if (mul_ack) begin
          cache_we = 1'b1;
          if (flush) begin
            state_d = StIdle;
          end else begin
            rsp_data_d = sel_half(op_q, mul_o[2*XLEN-1:0]);
            state_d    = StResp;
          end
        end else if (flush) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (mul_ack) begin
          cache_we = 1'b1;
          state_d  = StIdle;
        end
      end
      StResp: begin
        rsp_valid = ~rst;
        if (flush || rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign cache_valid_d = cache_valid_q | cache_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cache_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cache_valid_q <= cache_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q       <= op_d;
    a_q        <= a_d;
    b_q        <= b_d;
    rsp_data_q <= rsp_data_d;
    if (cache_we) begin
      cache_a_q <= a_q;
      cache_b_q <= b_q;
      cache_p_q <= mul_o[2*XLEN-1:0];
    end
  end

  assign rsp_data = rsp_data_q;
  assign mul_a    = a_q;
  assign mul_b    = b_q;

endmodule
